// File: rtl/memory_unit.sv
// Word-addressed 256 x 16 memory behind a CPU-style MAR/MBR interface.
// A small IDLE/RD/WR controller accepts one request at a time. Reads complete
// after RD_LAT edges, writes after one edge. Protocol misuse raises a sticky
// err flag. A preload port fills the array at boot without a CPU request.
module memory_unit #(
   parameter int RD_LAT = 2,   // read latency in edges, legal 1..4
   parameter int DEPTH  = 256  // word count, tied to the 8-bit address
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] control_signal,
   input  logic [7:0]  addr_from_MAR,
   input  logic [15:0] data_from_MBR,
   output logic [15:0] data_to_MBR,
   output logic        ready,
   output logic        err,
   input  logic        load_en,
   input  logic [7:0]  load_addr,
   input  logic [15:0] load_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } state_t;

   // The counter is loaded with RD_LAT-1 and completes the read when it hits 0.
   localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

   state_t      state, state_d;
   logic [1:0]  cnt, cnt_d;
   logic [7:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_d;
   logic        err_d;

   logic        rd_req, wr_req, any_req;
   logic        mem_we;
   logic [7:0]  mem_waddr;
   logic [15:0] mem_wdata;

   logic [15:0] mem [DEPTH];

   // Only bits 2 and 19 of the control word mean anything to this block.
   logic unused_ctrl;
   assign unused_ctrl = ^{control_signal[31:20], control_signal[18:3],
                          control_signal[1:0]};

   assign rd_req  = control_signal[2];
   assign wr_req  = control_signal[19];
   assign any_req = rd_req | wr_req;
   assign ready   = (state == IDLE);

   // Next-state, latch updates, error detection and memory write selection.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_d   = state;
      cnt_d     = cnt;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = data_to_MBR;
      err_d     = err;
      mem_we    = 1'b0;
      mem_waddr = addr_q;
      mem_wdata = wdata_q;

      unique case (state)
         IDLE: begin
            if (rd_req && wr_req) begin
               // Conflicting request: do nothing but flag it.
               err_d = 1'b1;
            end else if (rd_req) begin
               addr_d  = addr_from_MAR;
               cnt_d   = CNT_INIT;
               state_d = RD;
            end else if (wr_req) begin
               addr_d  = addr_from_MAR;
               wdata_d = data_from_MBR;
               state_d = WR;
            end
            // Preload is honoured only when the CPU side is quiet.
            if (load_en) begin
               if (any_req) begin
                  err_d = 1'b1;
               end else begin
                  mem_we    = 1'b1;
                  mem_waddr = load_addr;
                  mem_wdata = load_data;
               end
            end
         end

         RD: begin
            if (any_req || load_en) err_d = 1'b1;
            if (cnt == 2'd0) begin
               rdata_d = mem[addr_q];
               state_d = IDLE;
            end else begin
               cnt_d = cnt - 2'd1;
            end
         end

         WR: begin
            if (any_req || load_en) err_d = 1'b1;
            mem_we  = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // Controller registers; reset has priority over every request and load.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from values sampled before the edge.
      if (rst) begin
         state       <= IDLE;
         cnt         <= 2'd0;
         addr_q      <= 8'd0;
         wdata_q     <= 16'd0;
         data_to_MBR <= 16'd0;
         err         <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         data_to_MBR <= rdata_d;
         err         <= err_d;
      end
   end

   // Storage array: a write in the reset cycle is dropped so an aborted
   // write never reaches memory.
   always_ff @(posedge clk) begin
      // NOTE: the array itself is deliberately not reset; its contents must
      // survive rst and clearing it would prevent RAM mapping.
      if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
   end

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit. Three instances (RD_LAT = 1, 2, 4)
// share one stimulus stream; a reference memory array and per-instance
// expected read data predict every observed value.
module tb_memory_unit;

   localparam int N = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ctrl;
   logic [7:0]  addr;
   logic [15:0] wdata;
   logic        load_en;
   logic [7:0]  load_addr;
   logic [15:0] load_data;

   logic [15:0] dout [N];
   logic        rdy  [N];
   logic        erf  [N];

   int total = 0;
   int bad   = 0;

   logic [15:0] ref_mem [256];
   logic [15:0] last_rd [N];
   logic [7:0]  known [$];
   logic        exp_err;

   always #5 clk = ~clk;

   memory_unit #(.RD_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst), .control_signal(ctrl), .addr_from_MAR(addr),
      .data_from_MBR(wdata), .data_to_MBR(dout[0]), .ready(rdy[0]), .err(erf[0]),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

   memory_unit #(.RD_LAT(2)) u_lat2 (
      .clk(clk), .rst(rst), .control_signal(ctrl), .addr_from_MAR(addr),
      .data_from_MBR(wdata), .data_to_MBR(dout[1]), .ready(rdy[1]), .err(erf[1]),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

   memory_unit #(.RD_LAT(4)) u_lat4 (
      .clk(clk), .rst(rst), .control_signal(ctrl), .addr_from_MAR(addr),
      .data_from_MBR(wdata), .data_to_MBR(dout[2]), .ready(rdy[2]), .err(erf[2]),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

   // Hard time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "time limit reached");
   end

   function automatic int lat(input int i);
      case (i)
         0:       return 1;
         1:       return 2;
         default: return 4;
      endcase
   endfunction

   // Random filler for the ignored control bits, request bits forced low.
   function automatic logic [31:0] noise();
      return $urandom & ~32'h0008_0004;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge; outputs are sampled and inputs driven on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      for (int i = 0; i < N; i++) begin
         check({tag, "_ready"}, 32'(rdy[i]), 32'd1);
         check({tag, "_err"},   32'(erf[i]), 32'(exp_err));
         check({tag, "_data"},  32'(dout[i]), 32'(last_rd[i]));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ctrl = noise();
      step();
      step();
      rst = 1'b0;
      exp_err = 1'b0;
      for (int i = 0; i < N; i++) last_rd[i] = 16'h0000;
   endtask

   task automatic do_load(input logic [7:0] a, input logic [15:0] d);
      load_en = 1'b1;
      load_addr = a;
      load_data = d;
      step();
      load_en = 1'b0;
      load_addr = $urandom;
      ref_mem[a] = d;
      known.push_back(a);
      for (int i = 0; i < N; i++) check("load_ready", 32'(rdy[i]), 32'd1);
   endtask

   task automatic do_write(input logic [7:0] a, input logic [15:0] d);
      ctrl = noise() | 32'h0008_0000;
      addr = a;
      wdata = d;
      step();
      ctrl = noise();
      addr = $urandom;
      wdata = $urandom;
      for (int i = 0; i < N; i++) begin
         check("wr_busy", 32'(rdy[i]), 32'd0);
         check("wr_data_held", 32'(dout[i]), 32'(last_rd[i]));
      end
      step();
      ref_mem[a] = d;
      known.push_back(a);
      for (int i = 0; i < N; i++) begin
         check("wr_done_ready", 32'(rdy[i]), 32'd1);
         check("wr_done_data_held", 32'(dout[i]), 32'(last_rd[i]));
      end
   endtask

   // Each instance must stay busy for exactly its latency and present the
   // model's word on the edge that ends the read.
   task automatic do_read(input logic [7:0] a);
      logic [15:0] expv;
      expv = ref_mem[a];
      ctrl = noise() | 32'h0000_0004;
      addr = a;
      step();
      ctrl = noise();
      addr = $urandom;
      for (int i = 0; i < N; i++) check("rd_busy", 32'(rdy[i]), 32'd0);
      for (int j = 1; j <= 4; j++) begin
         step();
         for (int i = 0; i < N; i++) begin
            if (j < lat(i)) begin
               check("rd_wait_ready", 32'(rdy[i]), 32'd0);
               check("rd_wait_data", 32'(dout[i]), 32'(last_rd[i]));
            end else if (j == lat(i)) begin
               check("rd_done_ready", 32'(rdy[i]), 32'd1);
               check("rd_done_data", 32'(dout[i]), 32'(expv));
            end
         end
      end
      for (int i = 0; i < N; i++) last_rd[i] = expv;
   endtask

   initial begin
      rst = 1'b1;
      ctrl = 32'd0;
      addr = 8'd0;
      wdata = 16'd0;
      load_en = 1'b0;
      load_addr = 8'd0;
      load_data = 16'd0;
      exp_err = 1'b0;

      // Reset state.
      do_reset();
      check_idle("reset");

      // Preload then read with exact latency.
      do_load(8'h10, 16'hA5A5);
      do_read(8'h10);
      check_idle("preload_read");

      // Write then read back the new word.
      do_write(8'h20, 16'h1234);
      do_read(8'h20);

      // Address boundaries.
      do_load(8'hFF, 16'hF00F);
      do_load(8'h00, 16'h0FF0);
      do_read(8'hFF);
      do_read(8'h00);
      do_write(8'hFF, 16'h8001);
      do_read(8'hFF);
      check_idle("boundary");

      // Both request bits together: nothing happens, err latches.
      do_load(8'h30, 16'h3030);
      ctrl = noise() | 32'h0008_0004;
      addr = 8'h30;
      wdata = 16'hFFFF;
      step();
      ctrl = noise();
      exp_err = 1'b1;
      check_idle("both_req");
      step();
      check_idle("both_req_hold");
      do_read(8'h30);
      check_idle("both_req_mem");
      do_reset();
      check_idle("err_cleared");

      // Read request repeated while reading.
      do_load(8'h55, 16'h1357);
      ctrl = noise() | 32'h0000_0004;
      addr = 8'h55;
      step();
      addr = 8'h30;
      step();
      ctrl = noise();
      for (int j = 0; j < 4; j++) step();
      exp_err = 1'b1;
      for (int i = 0; i < N; i++) last_rd[i] = 16'h1357;
      check_idle("rd_repeat");
      do_reset();

      // Load alongside a write request, then load during the write cycle.
      do_load(8'h61, 16'h1111);
      do_load(8'h63, 16'h2222);
      ctrl = noise() | 32'h0008_0000;
      addr = 8'h62;
      wdata = 16'h3333;
      load_en = 1'b1;
      load_addr = 8'h63;
      load_data = 16'hBEEF;
      step();
      ctrl = noise();
      load_addr = 8'h61;
      load_data = 16'hDEAD;
      step();
      load_en = 1'b0;
      ref_mem[8'h62] = 16'h3333;
      exp_err = 1'b1;
      check_idle("load_conflict");
      do_read(8'h62);
      do_read(8'h63);
      do_read(8'h61);
      do_reset();

      // Reset the cycle after a write request: the write is abandoned.
      do_load(8'h40, 16'h0000);
      ctrl = noise() | 32'h0008_0000;
      addr = 8'h40;
      wdata = 16'hBEEF;
      step();
      ctrl = noise();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_err = 1'b0;
      for (int i = 0; i < N; i++) last_rd[i] = 16'h0000;
      check_idle("rst_mid_write");
      do_read(8'h40);

      // Reset beats a simultaneous bad request and a load.
      do_load(8'h70, 16'h7777);
      ctrl = 32'h0008_0004;
      load_en = 1'b1;
      load_addr = 8'h70;
      load_data = 16'h9999;
      rst = 1'b1;
      step();
      rst = 1'b0;
      load_en = 1'b0;
      ctrl = noise();
      for (int i = 0; i < N; i++) last_rd[i] = 16'h0000;
      check_idle("rst_priority");
      do_read(8'h70);

      // Random legal traffic against the reference model.
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 2))
            0: do_read(known[$urandom_range(0, known.size() - 1)]);
            1: do_write(8'($urandom), 16'($urandom));
            default: do_load(8'($urandom), 16'($urandom));
         endcase
      end
      check_idle("random_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Interface
- REQ-001 SHALL have parameter RD_LAT, default 2, meaning read latency in cycles from request edge to data-valid edge (legal 1..4).
- REQ-002 SHALL have parameter DEPTH, default 256, meaning word count (fixed by 8-bit address).
- REQ-003 SHALL have port clk, input, 1, the single rising-edge clock.
- REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
- REQ-005 SHALL have port control_signal, input, 32, CPU control word; bit 2 = read request, bit 19 = write request; all other bits ignored.
- REQ-006 SHALL have port addr_from_MAR, input, 8, word address sampled with a request.
- REQ-007 SHALL have port data_from_MBR, input, 16, write data sampled with a write request.
- REQ-008 SHALL have port data_to_MBR, output, 16, last read data, held until the next read completes.
- REQ-009 SHALL have port ready, output, 1, high when idle and accepting requests.
- REQ-010 SHALL have port err, output, 1, sticky protocol-error flag.
- REQ-011 SHALL have port load_en, input, 1, bench/boot preload strobe.
- REQ-012 SHALL have port load_addr, input, 8, preload address.
- REQ-013 SHALL have port load_data, input, 16, preload data.

Function
- REQ-014 SHALL store DEPTH x 16-bit words; contents SHALL NOT be cleared by rst.
- REQ-015 SHALL implement FSM states IDLE, RD, WR; ready = 1 only in IDLE.
- REQ-016 IDLE, bit2=1, bit19=0 at edge k: latch address, load latency counter with RD_LAT-1, go to RD.
- REQ-017 RD: counter decrements each edge; on the edge where the counter is 0, data_to_MBR <= mem[latched addr], go to IDLE; data becomes valid after edge k+RD_LAT.
- REQ-018 IDLE, bit19=1, bit2=0 at edge k: latch address and data_from_MBR, go to WR; edge k+1 writes the word, returns to IDLE.
- REQ-019 Write SHALL NOT change data_to_MBR.
- REQ-020 A read issued after a write to the same address has completed SHALL return the new data.
- REQ-021 Bit2 and bit19 both high in IDLE: neither operation performed, err set, stay IDLE.
- REQ-022 Any request (bit2 or bit19) seen while in RD or WR: ignored, err set; the in-flight operation completes unchanged.
- REQ-023 load_en=1 in IDLE with no request: mem[load_addr] <= load_data that edge; state unchanged.
- REQ-024 load_en=1 together with a request, or outside IDLE: load ignored, err set; the request (if legal) proceeds.
- REQ-025 err SHALL clear only on rst.
- REQ-026 Address SHALL be used as unsigned 0..255 with no wrap or offset logic.

Reset
- REQ-027 rst at an edge: state IDLE, ready=1, err=0, data_to_MBR=0, counter=0, latches cleared.
- REQ-028 rst mid-read or mid-write: the operation is abandoned; an aborted write SHALL NOT modify memory.
- REQ-029 rst SHALL take priority over requests and load in the same cycle.

Verification
- REQ-030 Preload mem[0x10]=0xA5A5; read 0x10 with RD_LAT=2 -> ready low 2 cycles, data_to_MBR=0xA5A5 after edge k+2, ready=1.
- REQ-031 Write 0x1234 to 0x20, then read 0x20 -> ready low 1 cycle for the write; the read returns 0x1234; data_to_MBR unchanged during the write.
- REQ-032 Bit2 and bit19 high together at 0x30 -> err=1, memory and data_to_MBR unchanged, ready stays 1.
- REQ-033 Read request repeated during RD -> err=1, original read completes with the correct data.
- REQ-034 rst asserted the cycle after a write request to 0x40 (old 0x0000) -> mem[0x40] still 0x0000, ready=1, err=0, data_to_MBR=0.
- REQ-035 Read 0xFF and 0x00 with RD_LAT=1 and RD_LAT=4 -> correct boundary data at exact latencies.
